seven_seg_scan: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/seven_seg_decode.sv | 43 ++++
 rtl/seven_seg_scan.sv | 128 ++++++++++++
 tb/tb_seven_seg_scan.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and glyph constants for the seven-segment scan driver.
// Segment vectors are active-low, ordered {a,b,c,d,e,f,g} (bit 6 = a).
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001111;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0000100;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational digit-to-glyph decoder.
// Ports:
//   code  in  4  digit code 0..15
//   blank in  1  force all segments off
//   seg   out 7  active-low segments {a..g}
// HEX_MODE=0 shows codes 10..15 as blank; HEX_MODE=1 shows A b C d E F.
module seven_seg_decode
    import seven_seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    input  logic       blank,
    output seg_t       seg
);

    localparam bit HEX_EN = (HEX_MODE != 0);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = HEX_EN ? SEG_A : SEG_BLANK;
                4'hB: seg = HEX_EN ? SEG_B : SEG_BLANK;
                4'hC: seg = HEX_EN ? SEG_C : SEG_BLANK;
                4'hD: seg = HEX_EN ? SEG_D : SEG_BLANK;
                4'hE: seg = HEX_EN ? SEG_E : SEG_BLANK;
                default: seg = HEX_EN ? SEG_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver.
// Ports:
//   clk      in  1         system clock
//   rst      in  1         asynchronous active-high reset
//   load     in  1         strobe: capture value and dp_in into shadow regs
//   value    in  4*DIGITS  packed digits, [3:0] = digit 0 (rightmost)
//   dp_in    in  DIGITS    decimal-point enables, 1 = lit
//   blank_lz in  1         live leading-zero suppression enable
//   seven    out 7         active-low segments {a..g}
//   dp       out 1         active-low decimal point
//   an       out DIGITS    active-low anode enables
// Each digit slot lasts REFRESH_DIV cycles; its first cycle is a dark
// guard cycle so segment data never overlaps an anode change.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int HEX_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seven,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PS_W  = $clog2(REFRESH_DIV);

    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [PS_W-1:0]     r_ps;
    logic [IDX_W-1:0]    r_idx;
    seg_t                r_seven;
    logic                r_dp_out;
    logic [DIGITS-1:0]   r_an;

    logic                w_guard;
    logic                w_ps_wrap;
    logic                w_idx_wrap;
    logic                w_zero_run;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_code;
    logic                w_dp_bit;
    logic                w_lz_sel;
    logic                w_blank;
    logic [DIGITS-1:0]   w_an;
    seg_t                w_seg;

    assign w_guard    = (r_ps == '0);
    assign w_ps_wrap  = (r_ps == PS_W'(REFRESH_DIV - 1));
    assign w_idx_wrap = (r_idx == IDX_W'(DIGITS - 1));

    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        w_code     = '0;
        w_dp_bit   = 1'b0;
        w_lz_sel   = 1'b0;
        w_an       = '1;
        // w_lz[k] is set when digit k and every digit above it are zero;
        // built from the top digit downward as a running AND.
        for (int unsigned j = DIGITS; j > 0; j--) begin
            w_zero_run = w_zero_run & (r_shadow_val[4*(j-1) +: 4] == 4'd0);
            w_lz[j-1]  = w_zero_run;
        end
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_code   = r_shadow_val[4*k +: 4];
                w_dp_bit = r_shadow_dp[k];
                w_lz_sel = w_lz[k];
                w_an[k]  = 1'b0;
            end
        end
        // Digit 0 is never suppressed so a zero value still shows "0".
        w_blank = blank_lz && (r_idx != '0) && w_lz_sel;
    end

    seven_seg_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .code  (w_code),
        .blank (w_blank),
        .seg   (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_ps         <= '0;
            r_idx        <= '0;
            r_seven      <= SEG_BLANK;
            r_dp_out     <= 1'b1;
            r_an         <= '1;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_ps_wrap) begin
                r_ps  <= '0;
                r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_ps <= r_ps + 1'b1;
            end
            if (w_guard) begin
                r_seven  <= SEG_BLANK;
                r_dp_out <= 1'b1;
                r_an     <= '1;
            end else begin
                r_seven  <= w_seg;
                r_dp_out <= ~w_dp_bit;
                r_an     <= w_an;
            end
        end
    end

    assign seven = r_seven;
    assign dp    = r_dp_out;
    assign an    = r_an;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

    localparam int D  = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          blank_lz = 1'b0;

    logic [6:0]    seven1, seven0;
    logic          dp1, dp0;
    logic [3:0]    an1, an0;

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(.DIGITS(D), .REFRESH_DIV(RD), .HEX_MODE(1)) dut_hex (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seven(seven1), .dp(dp1), .an(an1)
    );

    seven_seg_scan #(.DIGITS(D), .REFRESH_DIV(RD), .HEX_MODE(0)) dut_dec (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seven(seven0), .dp(dp0), .an(an0)
    );

    // Glyph table indexed by digit code.
    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: cycle count since reset release determines slot and
    // phase; a captured copy of value/dp_in feeds the glyph rules.
    int          n;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seven1, exp_seven0;
    logic        exp_dp;

    always @(posedge clk or posedge rst) begin
        int phase, slot, code;
        bit blank;
        if (rst) begin
            n = 0; m_val = '0; m_dp = '0;
            exp_an = 4'hF; exp_seven1 = 7'h7F; exp_seven0 = 7'h7F; exp_dp = 1'b1;
        end else begin
            phase = n % RD;
            slot  = (n / RD) % D;
            if (phase == 0) begin
                exp_an = 4'hF; exp_seven1 = 7'h7F; exp_seven0 = 7'h7F; exp_dp = 1'b1;
            end else begin
                code  = int'((m_val >> (4 * slot)) & 16'hF);
                blank = blank_lz && slot != 0 && (m_val >> (4 * slot)) == 16'd0;
                exp_an     = ~(4'b0001 << slot);
                exp_seven1 = blank ? 7'h7F : glyph[code];
                exp_seven0 = (blank || code > 9) ? 7'h7F : glyph[code];
                exp_dp     = ~m_dp[slot];
            end
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
            n++;
        end
    end

    logic [23:0] got, want;
    assign got  = {an1, seven1, dp1, an0, seven0, dp0};
    assign want = {exp_an, exp_seven1, exp_dp, exp_an, exp_seven0, exp_dp};

    // Called at a negedge; load is captured by the following posedge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Wait (bounded) for a negedge at which the model cycle count sits at
    // the requested slot/phase.
    task automatic wait_slot(input int slot, input int phase);
        int k = 0;
        @(negedge clk);
        while (!((n % RD) == phase && ((n / RD) % D) == slot) && k < 64) begin
            @(negedge clk);
            k++;
        end
        tot++;
        if (k >= 64) begin
            bad++;
            $display("FAIL wait_slot: slot %0d phase %0d not reached, got n=%0d", slot, phase, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tot++;
        if ({an1, seven1, dp1} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset_hold: got %b want %b", {an1, seven1, dp1}, {4'hF, 7'h7F, 1'b1});
        end
        rst = 1'b0;
        do_load(16'h1234, 4'b1111);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tot++;
        if ({an1, seven1, dp1} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset_async: got %b want %b", {an1, seven1, dp1}, {4'hF, 7'h7F, 1'b1});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tot++;
        if (an1 !== 4'hF) begin
            bad++;
            $display("FAIL reset_guard: got an=%b want 1111", an1);
        end
        @(negedge clk);
        tot++;
        if (an1 !== 4'b1110 || seven1 !== 7'b0000001) begin
            bad++;
            $display("FAIL reset_first_anode: got an=%b seven=%b want 1110 0000001", an1, seven1);
        end
    endtask

    task automatic test_scan();
        blank_lz = 1'b0;
        do_load(16'h1234, 4'b0000);
        repeat (2 * D * RD) begin
            @(negedge clk);
            tot++;
            if (got !== want) begin
                bad++;
                $display("FAIL scan: got %h want %h", got, want);
            end
        end
        repeat (8) begin
            blank_lz = 1'($urandom_range(1));
            do_load(16'($urandom), 4'($urandom));
            repeat (20) begin
                @(negedge clk);
                tot++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL scan_rand: got %h want %h val=%h", got, want, m_val);
                end
            end
        end
    endtask

    task automatic test_leading_zeros();
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000);
        wait_slot(3, 2);
        tot++;
        if (an1 !== 4'b0111 || seven1 !== 7'h7F) begin
            bad++;
            $display("FAIL lz_digit3: got an=%b seven=%b want 0111 1111111", an1, seven1);
        end
        repeat (D * RD) begin
            @(negedge clk);
            tot++;
            if (got !== want) begin
                bad++;
                $display("FAIL lz_0050: got %h want %h", got, want);
            end
        end
        do_load(16'h0000, 4'b0000);
        repeat (D * RD) begin
            @(negedge clk);
            tot++;
            if (got !== want) begin
                bad++;
                $display("FAIL lz_zero: got %h want %h", got, want);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_hex();
        do_load(16'hABCF, 4'b0000);
        wait_slot(0, 2);
        tot++;
        if (seven1 !== 7'b0111000 || seven0 !== 7'h7F) begin
            bad++;
            $display("FAIL hex_digit0: got %b/%b want 0111000/1111111", seven1, seven0);
        end
        repeat (D * RD) begin
            @(negedge clk);
            tot++;
            if (got !== want) begin
                bad++;
                $display("FAIL hex: got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_dp();
        do_load(16'h1234, 4'b0100);
        wait_slot(2, 2);
        tot++;
        if (dp1 !== 1'b0 || an1 !== 4'b1011) begin
            bad++;
            $display("FAIL dp_digit2: got dp=%b an=%b want 0 1011", dp1, an1);
        end
        repeat (D * RD) begin
            @(negedge clk);
            tot++;
            if (got !== want) begin
                bad++;
                $display("FAIL dp: got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_load(16'h1234, 4'b0000);
        wait_slot(1, 2);
        do_load(16'h9999, 4'b0000);
        @(negedge clk);
        tot++;
        if (an1 !== 4'b1101 || seven1 !== 7'b0000100) begin
            bad++;
            $display("FAIL load_mid: got an=%b seven=%b want 1101 0000100", an1, seven1);
        end
        wait_slot(2, 3);
        do_load(16'h5678, 4'b1000);
        @(negedge clk);
        tot++;
        if (an1 !== 4'hF) begin
            bad++;
            $display("FAIL load_wrap_guard: got an=%b want 1111", an1);
        end
        @(negedge clk);
        tot++;
        if (an1 !== 4'b0111 || seven1 !== 7'b0100100 || dp1 !== 1'b0) begin
            bad++;
            $display("FAIL load_wrap: got an=%b seven=%b dp=%b want 0111 0100100 0", an1, seven1, dp1);
        end
        repeat (D * RD) begin
            @(negedge clk);
            tot++;
            if (got !== want) begin
                bad++;
                $display("FAIL back_to_back: got %h want %h", got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_leading_zeros();
        test_hex();
        test_dp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
